// File: rtl/ccff_chain_programmer.sv
// ccff_chain_programmer
// Loader-side driver for the configuration chain. Bitstream words arrive on a
// valid/ready stream and are serialised LSB-first onto ccff_head while
// ccff_shift_en gates the fabric programming clock. When a load is started
// with verify set, ccff_tail is compared against the bit being shifted in.
// The tail shows the previous load's bit k during shift k, so resending the
// same bitstream must produce no mismatches.
module ccff_chain_programmer #(
   parameter int CHAIN_LEN = 29,
   parameter int DATA_W    = 8,
   localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              verify,
   input  logic [DATA_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              ccff_shift_en,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [CNT_W-1:0]  mismatch_cnt
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                verify_q, verify_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]    word_idx_q, word_idx_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic                head_q, head_d;
   logic                mismatch_q, mismatch_d;
   logic [CNT_W-1:0]    mismatch_cnt_q, mismatch_cnt_d;

   // Saturating increment: the failure count sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   // State and datapath registers; reset aborts any load in progress.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q        <= ST_IDLE;
         verify_q       <= 1'b0;
         bit_cnt_q      <= '0;
         word_idx_q     <= '0;
         shreg_q        <= '0;
         head_q         <= 1'b0;
         mismatch_q     <= 1'b0;
         mismatch_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         verify_q       <= verify_d;
         bit_cnt_q      <= bit_cnt_d;
         word_idx_q     <= word_idx_d;
         shreg_q        <= shreg_d;
         head_q         <= head_d;
         mismatch_q     <= mismatch_d;
         mismatch_cnt_q <= mismatch_cnt_d;
      end
   end

   // Next-state, serialiser, verify compare and state-decoded outputs.
   always_comb begin
      state_d        = state_q;
      verify_d       = verify_q;
      bit_cnt_d      = bit_cnt_q;
      word_idx_d     = word_idx_q;
      shreg_d        = shreg_q;
      head_d         = head_q;
      mismatch_d     = mismatch_q;
      mismatch_cnt_d = mismatch_cnt_q;
      bs_ready       = 1'b0;
      ccff_shift_en  = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               verify_d       = verify;
               bit_cnt_d      = '0;
               mismatch_d     = 1'b0;
               mismatch_cnt_d = '0;
               state_d        = ST_FETCH;
            end
         end

         ST_FETCH: begin
            // Chain holds while we wait for the next word; stalls are unbounded.
            bs_ready = 1'b1;
            if (bs_valid) begin
               shreg_d    = bs_data;
               head_d     = bs_data[0];
               word_idx_d = '0;
               state_d    = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            ccff_shift_en = 1'b1;
            shreg_d       = shreg_q >> 1;
            head_d        = shreg_d[0];
            word_idx_d    = word_idx_q + IDX_W'(1);
            bit_cnt_d     = bit_cnt_q + CNT_W'(1);
            if (verify_q && (ccff_tail != head_q)) begin
               mismatch_d     = 1'b1;
               mismatch_cnt_d = sat_inc(mismatch_cnt_q);
            end
            // The chain-length limit wins over the word boundary, so any
            // unused upper bits of the final word are dropped.
            if (bit_cnt_q == LAST_BIT) begin
               state_d = ST_DONE;
            end else if (word_idx_q == LAST_IDX) begin
               state_d = ST_FETCH;
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ccff_head    = head_q;
   assign mismatch     = mismatch_q;
   assign mismatch_cnt = mismatch_cnt_q;

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Bench for ccff_chain_programmer: a shift-register model of the fabric chain
// feeds ccff_tail, and each load is checked against the bitstream rules
// (LSB-first order, chain-length truncation, verify-compare counts).
module tb_ccff_chain_programmer;
   localparam int CHAIN_LEN = 29;
   localparam int DATA_W    = 8;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int NW        = (CHAIN_LEN + DATA_W - 1) / DATA_W;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic              prog_clk = 1'b0;
   logic              prog_reset_n = 1'b0;
   logic              start = 1'b0;
   logic              verify = 1'b0;
   logic [DATA_W-1:0] bs_data = '0;
   logic              bs_valid = 1'b0;
   logic              bs_ready;
   logic              ccff_head;
   logic              ccff_tail;
   logic              ccff_shift_en;
   logic              busy;
   logic              done;
   logic              mismatch;
   logic [CNT_W-1:0]  mismatch_cnt;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0]    words [NW];
   logic [CHAIN_LEN-1:0] prev_bits = '0;  // bit k of the last completed load
   logic [CHAIN_LEN-1:0] chain = '0;      // fabric chain, index 0 nearest ccff_head

   ccff_chain_programmer #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W)) dut (
      .prog_clk      (prog_clk),
      .prog_reset_n  (prog_reset_n),
      .start         (start),
      .verify        (verify),
      .bs_data       (bs_data),
      .bs_valid      (bs_valid),
      .bs_ready      (bs_ready),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail),
      .ccff_shift_en (ccff_shift_en),
      .busy          (busy),
      .done          (done),
      .mismatch      (mismatch),
      .mismatch_cnt  (mismatch_cnt)
   );

   always #5 prog_clk = ~prog_clk;

   // Fabric chain: captures ccff_head on each gated clock edge.
   always @(posedge prog_clk) begin
      if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   end
   assign ccff_tail = chain[CHAIN_LEN-1];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // One full load: host streams words[], optionally stalling one word in FETCH
   // and optionally poking start while busy. Checks against the bitstream rules.
   task automatic do_load(input bit vfy, input int stall_word, input int stall_len,
                          input bit poke, input string tag);
      int idx = 0, shifts = 0, accs = 0, stall_left = stall_len, exp_mm = 0;
      bit seen_done = 0, acc;
      logic [CHAIN_LEN-1:0] got = '0, exp_bits;
      for (int k = 0; k < CHAIN_LEN; k++) exp_bits[k] = words[k / DATA_W][k % DATA_W];
      if (vfy) begin
         for (int k = 0; k < CHAIN_LEN; k++) if (exp_bits[k] !== prev_bits[k]) exp_mm++;
         if (exp_mm > CNT_MAX) exp_mm = CNT_MAX;
      end

      @(posedge prog_clk); #1;
      start = 1'b1; verify = vfy; bs_valid = 1'b1; bs_data = words[0];
      @(negedge prog_clk);
      total++;
      if (bs_ready !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s idle_ready: got ready=%0b busy=%0b want 0 0", tag, bs_ready, busy);
      end
      @(posedge prog_clk); #1;
      start = 1'b0; verify = 1'($urandom);

      for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
         // drive for this cycle
         start = poke && (cyc == 5 || cyc == 15);
         if (idx < NW) begin
            bs_data = words[idx];
            if (idx == stall_word && stall_left > 0 && bs_ready) begin
               bs_valid = 1'b0;
               stall_left--;
               total++;
               if (ccff_shift_en !== 1'b0) begin
                  bad++;
                  $display("FAIL %s stall_shift_en: got %0b want 0", tag, ccff_shift_en);
               end
            end else begin
               bs_valid = 1'b1;
            end
         end else begin
            bs_valid = 1'b0;
            bs_data  = DATA_W'($urandom);
         end
         @(negedge prog_clk);
         acc = bs_valid && bs_ready;
         if (ccff_shift_en) begin
            if (shifts < CHAIN_LEN) got[shifts] = ccff_head;
            shifts++;
         end
         if (acc) accs++;
         if (done) seen_done = 1;
         if (!seen_done) begin
            @(posedge prog_clk); #1;
            if (acc) idx++;
         end
      end
      start = 1'b0; bs_valid = 1'b0;

      total++;
      if (!seen_done) begin
         bad++;
         $display("FAIL %s done_timeout: got no done want done pulse", tag);
      end
      total++;
      if (shifts !== CHAIN_LEN) begin
         bad++;
         $display("FAIL %s shift_count: got %0d want %0d", tag, shifts, CHAIN_LEN);
      end
      total++;
      if (got !== exp_bits) begin
         bad++;
         $display("FAIL %s head_order: got %h want %h", tag, got, exp_bits);
      end
      total++;
      if (accs !== NW) begin
         bad++;
         $display("FAIL %s words_accepted: got %0d want %0d", tag, accs, NW);
      end

      @(negedge prog_clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || ccff_shift_en !== 1'b0 || bs_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s after_done: got done=%0b busy=%0b sh=%0b rdy=%0b want 0 0 0 0",
                  tag, done, busy, ccff_shift_en, bs_ready);
      end
      total++;
      if (mismatch !== (exp_mm != 0)) begin
         bad++;
         $display("FAIL %s mismatch: got %0b want %0b", tag, mismatch, (exp_mm != 0));
      end
      total++;
      if (mismatch_cnt !== CNT_W'(exp_mm)) begin
         bad++;
         $display("FAIL %s mismatch_cnt: got %0d want %0d", tag, mismatch_cnt, exp_mm);
      end
      repeat (3) @(negedge prog_clk);
      total++;
      if (mismatch_cnt !== CNT_W'(exp_mm) || mismatch !== (exp_mm != 0)) begin
         bad++;
         $display("FAIL %s mismatch_hold: got %0b/%0d want %0b/%0d",
                  tag, mismatch, mismatch_cnt, (exp_mm != 0), exp_mm);
      end
      prev_bits = exp_bits;
   endtask

   task automatic test_reset();
      prog_reset_n = 1'b0;
      repeat (3) @(posedge prog_clk);
      @(negedge prog_clk);
      total++;
      if ({bs_ready, ccff_head, ccff_shift_en, busy, done, mismatch, mismatch_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_state: got rdy=%0b head=%0b sh=%0b busy=%0b done=%0b mm=%0b cnt=%0d want all 0",
                  bs_ready, ccff_head, ccff_shift_en, busy, done, mismatch, mismatch_cnt);
      end
      prog_reset_n = 1'b1;
      @(negedge prog_clk);
   endtask

   task automatic test_load_fixed();
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h12;
      do_load(1'b0, -1, 0, 1'b0, "load_fixed");
   endtask

   task automatic test_backpressure();
      for (int w = 0; w < NW; w++) words[w] = DATA_W'($urandom);
      do_load(1'b0, 2, 5, 1'b0, "backpressure");
   endtask

   task automatic test_verify_pass();
      for (int w = 0; w < NW; w++) words[w] = DATA_W'($urandom);
      do_load(1'b0, -1, 0, 1'b0, "vpass_load");
      do_load(1'b1, -1, 0, 1'b0, "vpass_verify");
   endtask

   task automatic test_verify_fail();
      for (int w = 0; w < NW; w++) words[w] = DATA_W'($urandom);
      do_load(1'b0, -1, 0, 1'b0, "vfail_load");
      words[3 / DATA_W][3 % DATA_W]   = ~words[3 / DATA_W][3 % DATA_W];
      words[17 / DATA_W][17 % DATA_W] = ~words[17 / DATA_W][17 % DATA_W];
      do_load(1'b1, 1, 2, 1'b0, "vfail_verify");
      total++;
      if (mismatch !== 1'b1 || mismatch_cnt !== CNT_W'(2)) begin
         bad++;
         $display("FAIL vfail_two_bits: got %0b/%0d want 1/2", mismatch, mismatch_cnt);
      end
   endtask

   // Reset mid-SHIFT with a failing verify in progress.
   task automatic test_abort();
      int n = 0;
      for (int k = 0; k < CHAIN_LEN; k++) words[k / DATA_W][k % DATA_W] = ~prev_bits[k];
      @(posedge prog_clk); #1;
      start = 1'b1; verify = 1'b1; bs_valid = 1'b1; bs_data = words[0];
      @(posedge prog_clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
         @(negedge prog_clk);
         if (ccff_shift_en) n++;
      end
      total++;
      if (n < 4 || mismatch !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre: got shifts=%0d mm=%0b want 4 1", n, mismatch);
      end
      prog_reset_n = 1'b0;
      #1;
      total++;
      if ({bs_ready, ccff_head, ccff_shift_en, busy, done, mismatch, mismatch_cnt} !== '0) begin
         bad++;
         $display("FAIL abort_reset: got rdy=%0b head=%0b sh=%0b busy=%0b done=%0b mm=%0b cnt=%0d want all 0",
                  bs_ready, ccff_head, ccff_shift_en, busy, done, mismatch, mismatch_cnt);
      end
      bs_valid = 1'b0;
      @(negedge prog_clk);
      prog_reset_n = 1'b1;
      @(negedge prog_clk);
      total++;
      if (ccff_shift_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle: got sh=%0b busy=%0b done=%0b want 0 0 0", ccff_shift_en, busy, done);
      end
      // chain now partially overwritten: refresh it with a plain load
      for (int w = 0; w < NW; w++) words[w] = DATA_W'($urandom);
      do_load(1'b0, -1, 0, 1'b0, "abort_reload");
   endtask

   task automatic test_busy_ignores();
      for (int w = 0; w < NW; w++) words[w] = DATA_W'($urandom);
      do_load(1'b1, 0, 1, 1'b1, "busy_ignores");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < NW; w++) words[w] = DATA_W'($urandom);
         if (($urandom % 3) == 0)
            for (int w = 0; w < NW; w++) words[w] = prev_bits[w*DATA_W +: DATA_W] ^ DATA_W'($urandom % 3);
         do_load(1'($urandom), int'($urandom % (NW + 1)), int'($urandom_range(0, 4)),
                 1'($urandom), $sformatf("random%0d", r));
      end
   endtask

   initial begin
      test_reset();
      test_load_fixed();
      test_verify_pass();
      test_verify_fail();
      test_abort();
      test_backpressure();
      test_busy_ignores();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
